// File: rtl/data_stream_pkg.sv
// Shared types, LFSR taps and pattern-step functions for the data stream generator.
// Both the top level and the pattern register use these so the word sequence is defined in one place.
package data_stream_pkg;

  localparam int          PAT_W            = 16;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Fibonacci feedback taps for the 16-bit LFSR: x^16 + x^14 + x^13 + x^11 + 1
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK1 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [PAT_W-1:0] first_word(mode_e mode, logic [PAT_W-1:0] fill,
                                                  logic [PAT_W-1:0] seed);
    logic [PAT_W-1:0] w;
    w = fill;
    case (mode)
      MODE_INCR:  w = fill;
      MODE_LFSR:  w = (fill == '0) ? seed : fill;
      MODE_CONST: w = fill;
      MODE_WALK1: w = 16'h0001 << fill[3:0];
      default:    w = fill;
    endcase
    return w;
  endfunction

  function automatic logic [PAT_W-1:0] next_word(mode_e mode, logic [PAT_W-1:0] cur);
    logic [PAT_W-1:0] w;
    w = cur;
    case (mode)
      MODE_INCR:  w = cur + 16'h0001;
      MODE_LFSR:  w = {cur[14:0],
                       cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
      MODE_CONST: w = cur;
      MODE_WALK1: w = {cur[14:0], cur[15]};
      default:    w = cur;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/data_stream_pattern.sv
// Current-word register: loads the first word of a burst, steps it on each accepted word,
// and clears to zero whenever no word is being presented.
module data_stream_pattern
  import data_stream_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic        i_clear,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_fill,
  output logic [15:0] o_word
);

  mode_e       r_mode;
  logic [15:0] r_word;

  // Clear wins over load so an abort or burst end always forces the bus to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word <= '0;
      r_mode <= MODE_INCR;
    end else if (i_clear) begin
      r_word <= '0;
      r_mode <= MODE_INCR;
    end else if (i_load) begin
      r_word <= first_word(mode_e'(i_mode), i_fill, LFSR_SEED);
      r_mode <= mode_e'(i_mode);
    end else if (i_advance) begin
      r_word <= next_word(r_mode, r_word);
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/data_stream_gen.sv
// Burst pattern source with valid/ready handshake; data is forced to zero whenever valid is low.
// Handshake: a word transfers on a rising edge where valid && ready; while valid && !ready, data and last hold.
module data_stream_gen
  import data_stream_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          LEN_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};

  state_e         r_state;
  state_e         w_next_state;
  logic [LEN_W:0] r_remaining;
  logic [LEN_W:0] w_remaining_next;
  logic           r_valid;
  logic           r_last;
  logic           r_busy;
  logic           r_done;
  logic           w_load;
  logic           w_advance;
  logic           w_clear;
  logic           w_handshake;
  logic [15:0]    w_word;

  assign w_handshake = r_valid && ready;

  always_comb begin
    w_next_state     = r_state;
    w_remaining_next = r_remaining;
    w_load           = 1'b0;
    w_advance        = 1'b0;
    w_clear          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_next_state     = RUN;
          w_load           = 1'b1;
          w_remaining_next = (burst_len == '0) ? REM_FULL : {1'b0, burst_len};
        end
      end
      RUN: begin
        // Abort outranks a handshake landing on the same edge.
        if (abort) begin
          w_next_state     = IDLE;
          w_clear          = 1'b1;
          w_remaining_next = '0;
        end else if (w_handshake) begin
          if (r_last) begin
            w_next_state     = DONE;
            w_clear          = 1'b1;
            w_remaining_next = '0;
          end else begin
            w_advance        = 1'b1;
            w_remaining_next = r_remaining - REM_ONE;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
        w_clear      = 1'b1;
      end
      default: begin
        w_next_state     = IDLE;
        w_clear          = 1'b1;
        w_remaining_next = '0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the registered data word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_remaining_next;
      r_valid     <= (w_next_state == RUN);
      r_last      <= (w_next_state == RUN) && (w_remaining_next == REM_ONE);
      r_busy      <= (w_next_state != IDLE);
      r_done      <= (w_next_state == DONE);
    end
  end

  data_stream_pattern #(
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_clear   (w_clear),
    .i_mode    (mode),
    .i_fill    (fill[15:0]),
    .o_word    (w_word)
  );

  assign data      = w_word;
  assign valid     = r_valid;
  assign last      = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_data_stream_gen.sv
// Directed bench for data_stream_gen: a table of single-cycle vectors plus hand-written
// sequences for reset behaviour, a full 256-word walking-one burst and mid-burst reset.
module tb_data_stream_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] fill;
  logic [7:0]  burst_len;
  logic        abort;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic [1:0]  mode;
    logic [15:0] fill;
    logic [7:0]  len;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  data_stream_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .fill      (fill),
    .burst_len (burst_len),
    .abort     (abort),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Held-word rule: an unaccepted word stays on the bus, unchanged, until taken or aborted.
  property p_hold;
    @(posedge clk) disable iff (!reset_n)
      (valid && !ready && !abort) |=> (valid && $stable(data) && $stable(last));
  endproperty
  a_hold: assert property (p_hold)
    else begin
      n_fail++;
      $display("FAIL hold_stable: data=%h valid=%b last=%b changed while stalled", data, valid, last);
    end

  // Zero-when-invalid invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (!valid && data !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_when_invalid: data=%h required 0000 with valid=0", data);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input logic r, input logic [1:0] m,
                       input logic [15:0] f, input logic [7:0] l);
    start     = s;
    abort     = a;
    ready     = r;
    mode      = m;
    fill      = f;
    burst_len = l;
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b data=%h last=%b busy=%b done=%b, want valid=%b data=%h last=%b busy=%b done=%b",
               name, act[19], act[18:3], act[2], act[1], act[0],
               exp[19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [19:0] outs();
    return {valid, data, last, busy, done};
  endfunction

  function automatic void add(input logic s, input logic a, input logic r, input logic [1:0] m,
                              input logic [15:0] f, input logic [7:0] l,
                              input logic ev, input logic [15:0] ed, input logic el,
                              input logic eb, input logic edn);
    vec_t v;
    v.start = s; v.abort = a; v.ready = r; v.mode = m; v.fill = f; v.len = l;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_busy = eb; v.e_done = edn;
    vecs.push_back(v);
  endfunction

  initial begin
    // INCR wrap, start while busy ignored, done pulse
    add(1, 0, 1, 2'd0, 16'hFFFE, 8'd4,   1, 16'hFFFE, 0, 1, 0);
    add(1, 0, 1, 2'd1, 16'h1234, 8'd7,   1, 16'hFFFF, 0, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   1, 16'h0000, 0, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   1, 16'h0001, 1, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 1, 1);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 0, 0);
    // start and abort together in IDLE: stays idle
    add(1, 1, 1, 2'd0, 16'h0005, 8'd4,   0, 16'h0000, 0, 0, 0);
    // LFSR from default seed with ready toggling
    add(1, 0, 0, 2'd1, 16'h0000, 8'd3,   1, 16'hACE1, 0, 1, 0);
    add(0, 0, 0, 2'd0, 16'h0000, 8'd0,   1, 16'hACE1, 0, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   1, 16'h59C3, 0, 1, 0);
    add(0, 0, 0, 2'd0, 16'h0000, 8'd0,   1, 16'h59C3, 0, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   1, 16'hB387, 1, 1, 0);
    add(0, 0, 0, 2'd0, 16'h0000, 8'd0,   1, 16'hB387, 1, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 1, 1);
    add(0, 0, 0, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 0, 0);
    // CONST, abort on word 3 with ready high, then a one-word burst
    add(1, 0, 1, 2'd2, 16'h1234, 8'd10,  1, 16'h1234, 0, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   1, 16'h1234, 0, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   1, 16'h1234, 0, 1, 0);
    add(0, 1, 1, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 0, 0);
    add(1, 0, 1, 2'd2, 16'h0055, 8'd1,   1, 16'h0055, 1, 1, 0);
    add(0, 0, 0, 2'd0, 16'h0000, 8'd0,   1, 16'h0055, 1, 1, 0);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 1, 1);
    add(0, 0, 1, 2'd0, 16'h0000, 8'd0,   0, 16'h0000, 0, 0, 0);

    drive(0, 0, 0, 2'd0, 16'h0000, 8'd0);
    reset_n = 1'b0;
    #1;
    check("in_reset", outs(), 20'h0);
    repeat (3) step();
    reset_n = 1'b1;
    ready   = 1'b1;

    // idle after reset release
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle%0d", i), outs(), 20'h0);
    end

    // table vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].ready, vecs[i].mode, vecs[i].fill, vecs[i].len);
      step();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].e_valid, vecs[i].e_data, vecs[i].e_last, vecs[i].e_busy, vecs[i].e_done});
    end

    // WALK1, fill=000F, burst_len=0 -> 256 words
    for (int i = 0; i < 256; i++) begin
      logic [15:0] one;
      one = 16'h0001;
      exp_q.push_back(one << ((15 + i) % 16));
    end
    drive(1, 0, 1, 2'd3, 16'h000F, 8'd0);
    step();
    drive(0, 0, 1, 2'd0, 16'h0000, 8'd0);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check($sformatf("walk%0d", i), outs(), {1'b1, e, (i == 255), 1'b1, 1'b0});
      step();
    end
    check("walk_done", outs(), {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1});
    step();
    check("walk_idle", outs(), 20'h0);

    // INCR, reset on word 5
    drive(1, 0, 1, 2'd0, 16'h0100, 8'd20);
    step();
    drive(0, 0, 1, 2'd0, 16'h0000, 8'd0);
    repeat (4) step();
    check("rst_word5", outs(), {1'b1, 16'h0104, 1'b0, 1'b1, 1'b0});
    reset_n = 1'b0;
    #1;
    check("rst_async", outs(), 20'h0);
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_idle%0d", i), outs(), 20'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/data_stream_gen.md
Name: data_stream_gen

Overview:
Source end of the 16-bit `data` bus watched by the reset/data assertion monitor.
- Generates bursts of pattern words (incrementing, LFSR, constant, walking-one) under a valid/ready handshake.
- Guarantees `data == 16'h0` whenever reset is active or no word is valid, so the monitor's post-reset property holds by construction.
- Sits between the test-control register block and the downstream consumer/monitor.

Parameters:
- DATA_W, 16, width of data word; only 16 is supported, because the LFSR taps are fixed.
- LEN_W, 8, width of burst_len; a value of 0 encodes 2^LEN_W words.
- LFSR_SEED, 16'hACE1, seed used when mode=LFSR and fill=0.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- mode  in  2  pattern: 0 INCR, 1 LFSR, 2 CONST, 3 WALK1; latched on start.
- fill  in  DATA_W  start value / seed / constant / walk position; latched on start.
- burst_len  in  LEN_W  number of words; latched on start.
- abort  in  1  terminates the burst.
- data  out  DATA_W  output word; registered.
- valid  out  1  data is valid; registered.
- ready  in  1  consumer accepts the word when valid&&ready.
- last  out  1  high with the final word of the burst.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after a burst completes normally.

Behaviour:
- Reset (async assert, sync-released internally by the flops' async clear only):
  - data=0, valid=0, last=0, busy=0, done=0.
  - State=IDLE; counters and latched config cleared.
- All outputs are driven straight from flops; no combinational path from any input to any output.
- States and transitions:
  - IDLE -> RUN on start. On that edge: latch mode, fill and burst_len; load remaining count (0 -> 256); compute the first word.
  - RUN: valid=1 starting the cycle after start (1-cycle latency).
  - RUN -> DONE after the handshake on the word with last=1.
  - DONE: lasts one cycle with done=1, valid=0, data=0, busy=1; then -> IDLE.
  - Any state except IDLE -> IDLE on abort. Abort has priority over a same-cycle handshake. Next cycle: valid=0, data=0, last=0; done is never pulsed.
- Handshake rules:
  - While valid && !ready: data and last are held stable. Required, and checked by assertion.
  - On valid && ready: advance to the next word the following cycle, with no bubble, so one word per cycle is possible while ready stays high.
  - valid never drops mid-burst except on abort.
- Invariant: data==0 whenever valid==0, including in IDLE, DONE, after abort, and during reset.
- start is ignored while busy; no queuing.
- start and abort in the same cycle in IDLE: abort wins and the block stays IDLE.
- last=1 exactly when the remaining count is 1. A burst_len=1 burst produces a single word with last=1.
- Patterns (word 0 = first word; arithmetic is modulo 2^16):
  - INCR: w0=fill, w(n+1)=w(n)+1; wraps 16'hFFFF -> 16'h0000.
  - LFSR: w0 = fill, or LFSR_SEED if fill==0. Fibonacci step w(n+1) = {w[14:0], w[15]^w[13]^w[12]^w[10]}. Nonzero state never reaches 0.
  - CONST: every word = fill.
  - WALK1: w0 = 1<<fill[3:0]; w(n+1) = rotate-left-by-1 of w(n), so bit 15 -> bit 0.
- Remaining-count width is LEN_W+1 so that 256 is representable.
- Reset mid-burst: outputs go to reset values immediately (async); the burst is lost.

Decomposition:
- Package data_stream_pkg:
  - mode enum: MODE_INCR, MODE_LFSR, MODE_CONST, MODE_WALK1.
  - state enum: IDLE, RUN, DONE.
  - LFSR tap constants and default seed.
  - pure function next_word(mode, cur).
- Sub-module data_stream_pattern: holds the current word register; ports load/advance/mode/fill; outputs the current word. Used by data_stream_gen.
- The top level holds the FSM, the remaining counter and the output registers.

Test Plan:
1. Reset release with ready=1, no start -> data=16'h0000, valid=0, busy=0 for 20 cycles; monitor property passes.
2. mode=INCR, fill=16'hFFFE, burst_len=4, ready=1 -> data FFFE, FFFF, 0000, 0001 on consecutive cycles starting 1 cycle after start; last on 0001; done pulses 1 cycle after the last handshake.
3. mode=LFSR, fill=0, burst_len=3, ready toggling 1/0 -> words ACE1, 59C3, B387 (per step rule); each held stable while ready=0.
4. mode=WALK1, fill=16'h000F, burst_len=0 -> 256 words: 8000, 0001, 0002, ...; last only on word 256.
5. mode=CONST, fill=16'h1234, burst_len=10, abort asserted on word 3 with ready=1 -> the next cycle has valid=0, data=0, busy=0; no done pulse; a new start is then accepted.
6. reset_n low mid-burst (INCR, word 5) -> data=0 and valid=0 within the same cycle; after release the block stays IDLE; start pulsed while busy is ignored (separate check: second start during RUN does not alter sequence).
